frame_store_ctrl: RTL
=====================

// Module: frame_store_ctrl
// PURPOSE
//  Downstream of pixel_sel. Captures one processed VGA frame into an 8-bit-per-pixel frame BRAM and plays it back.
//  Capture quantises pixel_sel's pixel_out/blank_out/vsync_out to RGB332 over a window.
//  Playback addresses the BRAM from raw hcount/vcount.
//  Drives bram_state and in_display_bram back into pixel_sel's output mux.
// PARAMETERS
//  IMG_W   320  captured window width (pixels)
//  IMG_H   240  captured window height (lines)
//  X0      0    window left edge (active-pixel x)
//  Y0      0    window top edge (active line y)
//  ADDR_W  17   BRAM address width; IMG_W*IMG_H <= 2**ADDR_W
// PORTS
//  clk              in   1       pixel clock
//  reset            in   1       synchronous, active-high
//  store_bram       in   1       user switch: rise=arm capture, low=release to live video
//  pixel_in         in   24      pixel_sel pixel_out, {R,G,B}
//  blank_in         in   1       pixel_sel blank_out, aligned with pixel_in
//  vsync_in         in   1       pixel_sel vsync_out, active-low
//  hcount           in   11      raw VGA hcount (undelayed)
//  vcount           in   10      raw VGA vcount (undelayed)
//  bram_we          out  1       BRAM write enable
//  bram_addr        out  ADDR_W  BRAM address (write or read)
//  bram_din         out  8       RGB332 write data
//  bram_state       out  2       IDLE/ARMED/WRITING_FRAME/READING_FRAME
//  in_display_bram  out  1       bram_dout valid and inside window (aligned with dout)
//  frame_done       out  1       1-cycle pulse when last pixel written
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; store_bram edge detector cleared.
//  Reset mid-write ends the write at the next edge.
//  store_bram low in any state -> IDLE next cycle; priority over all other transitions.
//  IDLE: store_bram 0->1 edge -> ARMED. A level held high across reset does not arm.
//  ARMED: vsync_in falling edge -> WRITING_FRAME; write address 0.
//  Local x/y counters, driven by blank_in/vsync_in:
//   - x: 0 while blank_in; +1 per active pixel.
//   - y: +1 on blank_in rising edge only if the line had >=1 active pixel; 0 on vsync_in low.
//  WRITING_FRAME: for x in [X0,X0+IMG_W) and y in [Y0,Y0+IMG_H), registered outputs next cycle:
//   - bram_we=1, bram_din={R[7:5],G[7:5],B[7:6]}, bram_addr=wr_addr; then wr_addr+1.
//   - Otherwise bram_we=0.
//   - Write at wr_addr=IMG_W*IMG_H-1: frame_done=1 that cycle, wr_addr stops, -> READING_FRAME.
//   - vsync_in fall before completion (short frame): wr_addr restarts at 0, stay WRITING_FRAME.
//  READING_FRAME: bram_we=0 always.
//   - rd_addr: 0 on vcount==0 && hcount==0; +1 per cycle with hcount/vcount in window.
//   - bram_addr=rd_addr, registered: 1 clk after hcount.
//   - BRAM read latency 1 clk, so bram_dout is valid 2 clk after hcount.
//   - in_display_bram = window hit delayed 2 clk, aligned with bram_dout.
//   - Stays READING_FRAME until store_bram low.
//  wr_addr/rd_addr never exceed IMG_W*IMG_H-1; no wrap.
//  in_display_bram=0 outside READING_FRAME.
// STRUCTURE
//  param.v gains bram_state codes: BRAM_IDLE=0, ARMED=1, WRITING_FRAME=2, READING_FRAME=3.
//  READING_FRAME must keep its existing value 3 in param.v.
//  Sub-module frame_xy_counter: x/y/active_line from blank_in, vsync_in.
//  Top: FSM, address counters, RGB332 pack, 2-stage window-hit delay.
// TESTING
//  1. Reset, store_bram=1 held through reset -> bram_state stays 0; toggle 0->1 -> 1.
//  2. ARMED, 640x480 timing, vsync fall -> state 2. Exactly 76800 we pulses, addrs 0..76799 in order.
//     frame_done pulse on the last pulse -> state 3 next cycle.
//  3. pixel_in=24'hFF8040 in window -> bram_din=8'b111_100_01. pixel outside window -> bram_we=0.
//  4. READING_FRAME: (hcount,vcount)=(0,0) -> bram_addr=0 1 clk later, in_display_bram=1 2 clk later.
//     (320,0) -> in_display_bram=0. (0,1) -> addr 320.
//  5. store_bram low mid-write at addr 1000 -> next cycle state 0, bram_we=0.
//     Re-arm -> new capture restarts at addr 0.
//  6. Reset asserted during READING_FRAME -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/frame_store_ctrl_pkg.sv
// frame_store_ctrl_pkg: bram_state codes and raster counter widths shared by the frame store
package frame_store_ctrl_pkg;
  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'd0,
    ARMED         = 2'd1,
    WRITING_FRAME = 2'd2,
    READING_FRAME = 2'd3
  } bram_state_t;
  localparam int XW = 11;
  localparam int YW = 10;
endpackage

// File: rtl/frame_store_ctrl_xy_counter.sv
// frame_xy_counter: recovers active-pixel x and active-line y from the processed blank/vsync stream
module frame_xy_counter
  import frame_store_ctrl_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_blank,
  input  logic          i_vsync,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);
  logic          r_blank_d;
  logic          r_active_line;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  assign o_x = r_x;
  assign o_y = r_y;
  // y advances only at the end of a line that actually carried pixels
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blank_d     <= 1'b0;
      r_active_line <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
    end else begin
      r_blank_d <= i_blank;
      r_x       <= i_blank ? '0 : r_x + 1'b1;
      if (!i_vsync) begin
        r_y           <= '0;
        r_active_line <= 1'b0;
      end else if (i_blank && !r_blank_d && r_active_line) begin
        r_y           <= r_y + 1'b1;
        r_active_line <= 1'b0;
      end else if (!i_blank) r_active_line <= 1'b1;
    end
  end
endmodule

// File: rtl/frame_store_ctrl.sv
// frame_store_ctrl: captures one RGB332 frame window into BRAM and plays it back from raw hcount/vcount
module frame_store_ctrl
  import frame_store_ctrl_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_store_bram,
  input  logic [23:0]       i_pixel_in,
  input  logic              i_blank_in,
  input  logic              i_vsync_in,
  input  logic [XW-1:0]     i_hcount,
  input  logic [YW-1:0]     i_vcount,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [7:0]        o_bram_din,
  output logic [1:0]        o_bram_state,
  output logic              o_in_display_bram,
  output logic              o_frame_done
);
  localparam logic [XW-1:0]     X_LO   = XW'(X0);
  localparam logic [XW-1:0]     X_SPAN = XW'(IMG_W);
  localparam logic [YW-1:0]     Y_LO   = YW'(Y0);
  localparam logic [YW-1:0]     Y_SPAN = YW'(IMG_H);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_W * IMG_H - 1);
  bram_state_t       r_state, w_next;
  logic              r_store_d, r_vsync_d, r_hit1, r_hit2;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr, w_rd_base;
  logic [XW-1:0]     w_x;
  logic [YW-1:0]     w_y;
  logic              w_vs_fall, w_cap_hit, w_play_hit, w_wr, w_last, w_rd_act;
  logic              w_unused;
  assign w_unused          = ^{i_pixel_in[20:16], i_pixel_in[12:8], i_pixel_in[5:0]};
  assign o_bram_state      = r_state;
  assign o_in_display_bram = r_hit2;
  frame_xy_counter u_xy (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_blank(i_blank_in),
    .i_vsync(i_vsync_in),
    .o_x    (w_x),
    .o_y    (w_y)
  );
  // window tests use modular subtraction so a zero left/top edge needs no >= 0 compare
  always_comb begin
    w_vs_fall  = r_vsync_d && !i_vsync_in;
    w_cap_hit  = !i_blank_in && ((w_x - X_LO) < X_SPAN) && ((w_y - Y_LO) < Y_SPAN);
    w_play_hit = ((i_hcount - X_LO) < X_SPAN) && ((i_vcount - Y_LO) < Y_SPAN);
    w_wr       = (r_state == WRITING_FRAME) && i_store_bram && w_cap_hit;
    w_last     = r_wr_addr == LAST;
    w_rd_act   = (r_state == READING_FRAME) && i_store_bram;
    w_rd_base  = (i_hcount == '0 && i_vcount == '0) ? '0 : r_rd_addr;
    w_next     = r_state;
    if (!i_store_bram) w_next = BRAM_IDLE;
    else if (r_state == BRAM_IDLE && !r_store_d) w_next = ARMED;
    else if (r_state == ARMED && w_vs_fall) w_next = WRITING_FRAME;
    else if (w_wr && w_last) w_next = READING_FRAME;
  end
  always_ff @(posedge i_clk) r_state <= i_reset ? BRAM_IDLE : w_next;
  // the store edge detector resets high so a switch already up through reset cannot arm
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_store_d    <= 1'b1;
      r_vsync_d    <= 1'b0;
      r_hit1       <= 1'b0;
      r_hit2       <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_din   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      r_store_d    <= i_store_bram;
      r_vsync_d    <= i_vsync_in;
      o_bram_we    <= w_wr;
      o_frame_done <= w_wr && w_last;
      r_hit1       <= w_rd_act && w_play_hit;
      r_hit2       <= w_rd_act && r_hit1;
      if (w_wr) begin
        o_bram_din  <= {i_pixel_in[23:21], i_pixel_in[15:13], i_pixel_in[7:6]};
        o_bram_addr <= r_wr_addr;
        r_wr_addr   <= w_last ? r_wr_addr : r_wr_addr + 1'b1;
      end else if (r_state != WRITING_FRAME || w_vs_fall) r_wr_addr <= '0;
      if (w_rd_act) o_bram_addr <= w_rd_base;
      r_rd_addr <= !w_rd_act ? '0 : (w_play_hit && w_rd_base != LAST) ? w_rd_base + 1'b1 : w_rd_base;
    end
  end
endmodule
